// File: rtl/time_event_capture.sv
// Event timestamp capture: a local seconds/sub-second time base stamps each event edge into a FWFT FIFO.
// Define EVENT_DEBOUNCE_EN to require DEB_CYC consecutive high cycles before an event is accepted.
module time_event_capture #(
    parameter int SEC_W      = 32,
    parameter int FRAC_W     = 32,
    parameter int DEPTH_LOG2 = 4,
    parameter int DEB_CYC    = 4
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  enable,
    input  logic                  pps_in,
    input  logic                  event_in,
    input  logic                  rd_en,
    input  logic                  clr_ovf,
    output logic                  rd_valid,
    output logic [SEC_W-1:0]      rd_sec,
    output logic [FRAC_W-1:0]     rd_frac,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  overflow,
    output logic [SEC_W-1:0]      sec_now,
    output logic [FRAC_W-1:0]     frac_now
);

    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int STAMP_W = SEC_W + FRAC_W;

    if (DEB_CYC < 1) begin : g_deb_cyc_check
        $error("DEB_CYC must be at least 1");
    end

    // ------------------------------------------------------------------
    // Input synchronisers and edge detection
    // ------------------------------------------------------------------
    logic pps_meta_q, pps_sync_q, pps_dly_q;
    logic ev_meta_q,  ev_sync_q;
    logic pps_rise;
    logic ev_rise;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            pps_meta_q <= 1'b0;
            pps_sync_q <= 1'b0;
            pps_dly_q  <= 1'b0;
            ev_meta_q  <= 1'b0;
            ev_sync_q  <= 1'b0;
        end else begin
            pps_meta_q <= pps_in;
            pps_sync_q <= pps_meta_q;
            pps_dly_q  <= pps_sync_q;
            ev_meta_q  <= event_in;
            ev_sync_q  <= ev_meta_q;
        end
    end

    assign pps_rise = pps_sync_q & ~pps_dly_q;

`ifdef EVENT_DEBOUNCE_EN
    // Count consecutive high cycles; fire once on the DEB_CYC-th, saturate until the line drops.
    localparam int DEB_CNT_W = $clog2(DEB_CYC + 1);
    localparam logic [DEB_CNT_W-1:0] DEB_MAX  = DEB_CNT_W'(DEB_CYC);
    localparam logic [DEB_CNT_W-1:0] DEB_FIRE = DEB_CNT_W'(DEB_CYC - 1);

    logic [DEB_CNT_W-1:0] deb_cnt_q, deb_cnt_d;

    always_comb begin
        deb_cnt_d = deb_cnt_q;
        if (!ev_sync_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q != DEB_MAX) begin
            deb_cnt_d = deb_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            deb_cnt_q <= '0;
        end else begin
            deb_cnt_q <= deb_cnt_d;
        end
    end

    assign ev_rise = ev_sync_q & (deb_cnt_q == DEB_FIRE);
`else
    logic ev_dly_q;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            ev_dly_q <= 1'b0;
        end else begin
            ev_dly_q <= ev_sync_q;
        end
    end

    assign ev_rise = ev_sync_q & ~ev_dly_q;
`endif

    // ------------------------------------------------------------------
    // Time base
    // ------------------------------------------------------------------
    logic [SEC_W-1:0]  sec_q,  sec_d;
    logic [FRAC_W-1:0] frac_q, frac_d;

    always_comb begin
        sec_d  = sec_q;
        frac_d = frac_q;
        if (enable) begin
            if (pps_rise) begin
                sec_d  = sec_q + 1'b1;
                frac_d = '0;
            end else begin
                frac_d = frac_q + 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            sec_q  <= '0;
            frac_q <= '0;
        end else begin
            sec_q  <= sec_d;
            frac_q <= frac_d;
        end
    end

    // ------------------------------------------------------------------
    // Stamp FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    logic [STAMP_W-1:0]    mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q,  count_d;
    logic                  ovf_q,    ovf_d;
    logic                  fifo_full, fifo_empty;
    logic                  push_req, do_push, do_pop, ovf_set;
    logic [STAMP_W-1:0]    head;

    assign fifo_full  = count_q[DEPTH_LOG2];
    assign fifo_empty = (count_q == '0);

    // A pop on a full FIFO frees the slot the same-cycle push needs.
    assign push_req = ev_rise & enable;
    assign do_pop   = rd_en & ~fifo_empty;
    assign do_push  = push_req & (~fifo_full | do_pop);
    assign ovf_set  = push_req & fifo_full & ~do_pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge ACLK) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= {sec_q, frac_q};
        end
    end

    assign head = mem_q[rd_ptr_q];

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rd_valid   = ~fifo_empty;
    assign rd_sec     = head[STAMP_W-1:FRAC_W];
    assign rd_frac    = head[FRAC_W-1:0];
    assign fifo_count = count_q;
    assign overflow   = ovf_q;
    assign sec_now    = sec_q;
    assign frac_now   = frac_q;

endmodule

// File: tb/tb_time_event_capture.sv
// Self-checking bench for time_event_capture: a reference time base predicts each stamp,
// stamps are queued on stimulus and compared as the FIFO is drained.
module tb_time_event_capture;

    localparam int SEC_W      = 32;
    localparam int FRAC_W     = 32;
    localparam int DEPTH_LOG2 = 4;
    localparam int DEB_CYC    = 4;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
`ifdef EVENT_DEBOUNCE_EN
    localparam int OFS  = 1 + DEB_CYC;
    localparam int EV_W = DEB_CYC + 2;
`else
    localparam int OFS  = 2;
    localparam int EV_W = 2;
`endif

    logic                ACLK = 1'b0;
    logic                ARESETN;
    logic                enable;
    logic                pps_in;
    logic                event_in;
    logic                rd_en;
    logic                clr_ovf;
    logic                rd_valid;
    logic [SEC_W-1:0]    rd_sec;
    logic [FRAC_W-1:0]   rd_frac;
    logic [DEPTH_LOG2:0] fifo_count;
    logic                overflow;
    logic [SEC_W-1:0]    sec_now;
    logic [FRAC_W-1:0]   frac_now;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    always #5 ACLK = ~ACLK;

    time_event_capture #(
        .SEC_W(SEC_W), .FRAC_W(FRAC_W), .DEPTH_LOG2(DEPTH_LOG2), .DEB_CYC(DEB_CYC)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .enable(enable), .pps_in(pps_in),
        .event_in(event_in), .rd_en(rd_en), .clr_ovf(clr_ovf),
        .rd_valid(rd_valid), .rd_sec(rd_sec), .rd_frac(rd_frac),
        .fifo_count(fifo_count), .overflow(overflow),
        .sec_now(sec_now), .frac_now(frac_now)
    );

    // Reference time base: a PPS edge driven before edge 1 takes effect at edge 3.
    logic [SEC_W-1:0]  m_sec;
    logic [FRAC_W-1:0] m_frac;
    logic [2:0]        m_pps;

    always @(posedge ACLK) begin
        if (!ARESETN) begin
            m_sec  <= '0;
            m_frac <= '0;
            m_pps  <= '0;
        end else begin
            m_pps <= {m_pps[1:0], pps_in};
            if (enable) begin
                if (m_pps[1] && !m_pps[2]) begin
                    m_sec  <= m_sec + 1'b1;
                    m_frac <= '0;
                end else begin
                    m_frac <= m_frac + 1'b1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge ACLK);
    endtask

    // Called on a negedge; the model values are those of the cycle in which the edge is driven.
    task automatic fire_event(input bit stored, input int width);
        logic [FRAC_W-1:0] f;
        f = m_frac + FRAC_W'(OFS);
        if (stored) exp_q.push_back({m_sec, f});
        event_in = 1'b1;
        cycles(width);
        event_in = 1'b0;
        cycles(4);
    endtask

    task automatic pop_check(input string tag);
        logic [63:0] e;
        check({tag, "_valid"}, rd_valid, 1'b1);
        check({tag, "_sb"}, exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check(tag, {rd_sec, rd_frac}, e);
        end
        $display("pop %s sec=%0d frac=%0d", tag, rd_sec, rd_frac);
        rd_en = 1'b1;
        cycles(1);
        rd_en = 1'b0;
    endtask

    task automatic do_reset();
        ARESETN = 1'b0;
        cycles(1);
        ARESETN = 1'b1;
        exp_q.delete();
    endtask

    initial begin
        ARESETN  = 1'b0;
        enable   = 1'b0;
        pps_in   = 1'b0;
        event_in = 1'b0;
        rd_en    = 1'b0;
        clr_ovf  = 1'b0;
        cycles(3);
        check("rst_valid", rd_valid, 1'b0);
        check("rst_count", fifo_count, 0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_sec", sec_now, 0);
        check("rst_frac", frac_now, 0);

        // Count and hold
        ARESETN = 1'b1;
        enable  = 1'b1;
        cycles(100);
        check("run_frac", frac_now, 100);
        check("run_sec", sec_now, 0);
        enable = 1'b0;
        cycles(10);
        check("hold_frac", frac_now, 100);
        check("hold_sec", sec_now, 0);

        // Single capture with frac_now == 40 at the input edge
        do_reset();
        enable = 1'b1;
        cycles(40);
        check("pre_frac40", frac_now, 40);
        fire_event(1'b1, EV_W);
        check("single_count", fifo_count, 1);
        check("single_frac", rd_frac, 40 + OFS);
        pop_check("single");
        check("single_empty", rd_valid, 1'b0);

`ifndef EVENT_DEBOUNCE_EN
        // PPS and event in the same cycle
        for (int i = 0; i < 3; i++) begin
            pps_in = 1'b1;
            cycles(2);
            pps_in = 1'b0;
            cycles(3);
        end
        check("pps_sec3", sec_now, 3);
        exp_q.push_back({m_sec, m_frac + FRAC_W'(OFS)});
        pps_in   = 1'b1;
        event_in = 1'b1;
        cycles(3);
        check("pps_sec4", sec_now, 4);
        check("pps_frac0", frac_now, 0);
        pps_in   = 1'b0;
        event_in = 1'b0;
        cycles(2);
        check("pps_frac2", frac_now, 2);
        check("coin_sec", rd_sec, 3);
        pop_check("coin");
`endif

        // Overflow: 17 events, no reads
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) fire_event(i < DEPTH, EV_W);
        check("ovf_count", fifo_count, DEPTH);
        check("ovf_flag", overflow, 1'b1);
        for (int i = 0; i < DEPTH; i++) pop_check($sformatf("ovf_pop%0d", i + 1));
        check("ovf_drained", rd_valid, 1'b0);
        check("ovf_cnt0", fifo_count, 0);
        check("ovf_sticky", overflow, 1'b1);
        clr_ovf = 1'b1;
        cycles(1);
        clr_ovf = 1'b0;
        check("ovf_clr", overflow, 1'b0);

        // Full FIFO with pop and push in the same cycle
        for (int i = 0; i < DEPTH; i++) fire_event(1'b1, EV_W);
        check("full_count", fifo_count, DEPTH);
        exp_q.push_back({m_sec, m_frac + FRAC_W'(OFS)});
        event_in = 1'b1;
        cycles(OFS);
        pop_check("full_head");
        event_in = 1'b0;
        cycles(4);
        check("fullrw_count", fifo_count, DEPTH);
        check("fullrw_ovf", overflow, 1'b0);
        for (int i = 0; i < DEPTH; i++) pop_check($sformatf("fullrw_pop%0d", i));
        check("fullrw_empty", rd_valid, 1'b0);

        // Reset with entries queued
        for (int i = 0; i < 5; i++) fire_event(1'b1, EV_W);
        check("mid_count5", fifo_count, 5);
        ARESETN = 1'b0;
        cycles(1);
        check("mid_valid", rd_valid, 1'b0);
        check("mid_count", fifo_count, 0);
        check("mid_sec", sec_now, 0);
        check("mid_frac", frac_now, 0);
        ARESETN = 1'b1;
        exp_q.delete();

`ifdef EVENT_DEBOUNCE_EN
        // Short pulse rejected, long pulse accepted
        cycles(2);
        fire_event(1'b0, 3);
        check("deb_short", fifo_count, 0);
        fire_event(1'b1, 6);
        check("deb_long", fifo_count, 1);
        pop_check("deb");
`endif

        check("sb_drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
